// File: rtl/ldpc_enc_addr_gen_mc.sv
// LDPC encoder address generator: walks the data columns of a runtime-selected base matrix
// and emits per-row word enable/select masks and bit shifts for the parity accumulators.
module ldpc_enc_addr_gen_mc #(
  parameter int pCODE_NUM = 4,
  parameter int pZF       = 64,
  parameter int pDAT_W    = 4,
  parameter int pC        = 4,
  parameter int pT        = 24,
  localparam int cBASE    = pZF / pDAT_W,
  localparam int cBS_W    = $clog2(pDAT_W + 1),
  localparam int cW_W     = $clog2(cBASE + 1),
  localparam int cCOL_W   = $clog2(pT + 1),
  localparam int cCODE_W  = $clog2(pCODE_NUM + 1)
) (
  input  logic                iclk,
  input  logic                ireset,
  input  logic                iclkena,
  input  logic                istart,
  input  logic [cCODE_W-1:0]  icode,
  input  logic                ienable,
  output logic                obusy,
  output logic                oval,
  output logic                osof,
  output logic                oeof,
  output logic [cCOL_W-1:0]   ocol,
  output logic [cW_W-1:0]     oword,
  output logic [cBASE-1:0]    obitena   [pC],
  output logic [cBASE-1:0]    obitsel   [pC],
  output logic [cBS_W-1:0]    obitshift [pC],
  output logic                odone,
  output logic                oerr
);

  localparam int cNCODE = 1 << cCODE_W;
  localparam int cNCOL  = 1 << cCOL_W;
  localparam logic [cCODE_W-1:0] cCODE_MAX  = cCODE_W'(pCODE_NUM - 1);
  localparam logic [cW_W-1:0]    cWORD_LAST = cW_W'(cBASE - 1);
  localparam logic [cBASE-1:0]   cONE       = cBASE'(1);

  // Codes 0 and 1 are hand-set; further codes/rows fall back to a deterministic filler.
  function automatic int get_Kb(input int k);
    int kb;
    if (k == 0)      kb = 2;
    else if (k == 1) kb = 3;
    else             kb = (2 + k < pT - pC) ? 2 + k : pT - pC;
    return kb;
  endfunction

  function automatic int get_Hb(input int k, input int c, input int t);
    int h;
    if (k == 0 && c == 0 && t < 2)      h = (t == 0) ? 5 : -1;
    else if (k == 0 && c == 1 && t < 2) h = (t == 0) ? 0 : 14;
    else if (k == 1 && c == 0 && t < 3) h = (t == 0) ? 14 : ((t == 1) ? -1 : 0);
    else if (k == 1 && c == 1 && t < 3) h = (t == 0) ? -1 : ((t == 1) ? 7 : 10);
    else if ((k + c + t) % 3 == 0)      h = -1;
    else                                h = (k * 17 + c * 7 + t * 5) % pZF;
    return h;
  endfunction

  function automatic int hb_a(input int h);
    return (cBASE - ((h / pDAT_W) % cBASE)) % cBASE;
  endfunction

  function automatic logic [cBASE-1:0] hb_ena(input int h);
    if (h < 0) return '0;
    return (cONE << hb_a(h)) | (cONE << ((hb_a(h) + cBASE - 1) % cBASE));
  endfunction

  function automatic logic [cBASE-1:0] hb_sel(input int h);
    return (h < 0) ? cONE : (cONE << hb_a(h));
  endfunction

  function automatic logic [cBS_W-1:0] hb_shift(input int h);
    return (h < 0) ? '0 : cBS_W'(h % pDAT_W);
  endfunction

  logic [cBASE-1:0]  tab_ena [cNCODE][pC][cNCOL];
  logic [cBASE-1:0]  tab_sel [cNCODE][pC][cNCOL];
  logic [cBS_W-1:0]  tab_sh  [cNCODE][pC][cNCOL];
  logic [cCOL_W-1:0] tab_kbl [cNCODE];

  for (genvar k = 0; k < cNCODE; k++) begin : g_code
    localparam int KB = (k < pCODE_NUM) ? get_Kb(k) : 1;
    assign tab_kbl[k] = cCOL_W'(KB - 1);
    for (genvar c = 0; c < pC; c++) begin : g_row
      for (genvar t = 0; t < cNCOL; t++) begin : g_col
        localparam int H = (k < pCODE_NUM && t < pT) ? get_Hb(k, c, t) : -1;
        assign tab_ena[k][c][t] = hb_ena(H);
        assign tab_sel[k][c][t] = hb_sel(H);
        assign tab_sh[k][c][t]  = hb_shift(H);
      end
    end
  end

  typedef enum logic {IDLE, RUN} state_t;
  state_t state;

  logic [cCODE_W-1:0] code_r;
  logic [cCOL_W-1:0]  kb_last;
  logic               start_ok, adv, last_word, last_col, ld, rot;
  logic [cCODE_W-1:0] ld_code;
  logic [cCOL_W-1:0]  ld_col;

  always_comb begin
    start_ok  = istart && (icode <= cCODE_MAX);
    adv       = !istart && (state == RUN) && ienable;
    last_word = (oword == cWORD_LAST);
    last_col  = (ocol == kb_last);
    ld        = start_ok || (adv && last_word && !last_col);
    rot       = adv && !last_word;
    ld_code   = istart ? icode : code_r;
    ld_col    = istart ? '0 : ocol + 1'b1;
  end

  assign osof = oval && (ocol == '0) && (oword == '0);
  assign oeof = oval && last_col && last_word;

  always_ff @(posedge iclk or posedge ireset) begin
    if (ireset) begin
      state   <= IDLE;
      code_r  <= '0;
      kb_last <= '0;
      ocol    <= '0;
      oword   <= '0;
      oval    <= 1'b0;
      obusy   <= 1'b0;
      odone   <= 1'b0;
      oerr    <= 1'b0;
    end else if (iclkena) begin
      odone <= 1'b0;
      oerr  <= 1'b0;
      if (istart) begin
        if (start_ok) begin
          state   <= RUN;
          oval    <= 1'b1;
          obusy   <= 1'b1;
          code_r  <= icode;
          kb_last <= tab_kbl[icode];
          ocol    <= '0;
          oword   <= '0;
        end else begin
          state <= IDLE;
          oval  <= 1'b0;
          obusy <= 1'b0;
          oerr  <= 1'b1;
        end
      end else if (adv) begin
        if (!last_word) begin
          oword <= oword + 1'b1;
        end else if (!last_col) begin
          oword <= '0;
          ocol  <= ocol + 1'b1;
        end else begin
          state <= IDLE;
          oval  <= 1'b0;
          obusy <= 1'b0;
          odone <= 1'b1;
        end
      end
    end
  end

  // Masks rotate within a column and reload on a column change; they hold in IDLE.
  for (genvar c = 0; c < pC; c++) begin : g_mask
    always_ff @(posedge iclk or posedge ireset) begin
      if (ireset) begin
        obitena[c]   <= '0;
        obitsel[c]   <= '0;
        obitshift[c] <= '0;
      end else if (iclkena) begin
        if (ld) begin
          obitena[c]   <= tab_ena[ld_code][c][ld_col];
          obitsel[c]   <= tab_sel[ld_code][c][ld_col];
          obitshift[c] <= tab_sh[ld_code][c][ld_col];
        end else if (rot) begin
          obitena[c] <= {obitena[c][cBASE-2:0], obitena[c][cBASE-1]};
          obitsel[c] <= {obitsel[c][cBASE-2:0], obitsel[c][cBASE-1]};
        end
      end
    end
  end

endmodule

// File: tb/tb_ldpc_enc_addr_gen_mc.sv
// Scoreboard bench for ldpc_enc_addr_gen_mc: expected words are queued at frame start
// and compared against the DUT on every cycle while the frame is valid.
`timescale 1ns/100ps
module tb_ldpc_enc_addr_gen_mc;

  logic       iclk = 1'b0;
  logic       ireset, iclkena, istart, ienable;
  logic [1:0] icode;
  logic       obusy, oval, osof, oeof, odone, oerr;
  logic [3:0] ocol;
  logic [2:0] oword;
  logic [3:0] obitena   [2];
  logic [3:0] obitsel   [2];
  logic [2:0] obitshift [2];

  ldpc_enc_addr_gen_mc #(
    .pCODE_NUM (2),
    .pZF       (16),
    .pDAT_W    (4),
    .pC        (2),
    .pT        (8)
  ) dut (
    .iclk      (iclk),
    .ireset    (ireset),
    .iclkena   (iclkena),
    .istart    (istart),
    .icode     (icode),
    .ienable   (ienable),
    .obusy     (obusy),
    .oval      (oval),
    .osof      (osof),
    .oeof      (oeof),
    .ocol      (ocol),
    .oword     (oword),
    .obitena   (obitena),
    .obitsel   (obitsel),
    .obitshift (obitshift),
    .odone     (odone),
    .oerr      (oerr)
  );

  always #5 iclk = ~iclk;

  typedef struct packed {
    logic [3:0]      col;
    logic [2:0]      word;
    logic            sof;
    logic            eof;
    logic [1:0][3:0] ena;
    logic [1:0][3:0] sel;
    logic [1:0][2:0] sh;
  } exp_t;

  exp_t sb[$];
  exp_t last;
  logic exp_done, exp_err;
  int   acc_cnt;
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, act, req, $time);
    end
  endtask

  function automatic int hb(input int code, input int r, input int t);
    case (code * 16 + r * 4 + t)
      0:  return 5;
      4:  return 0;
      5:  return 14;
      16: return 14;
      18: return 0;
      21: return 7;
      22: return 10;
      default: return -1;
    endcase
  endfunction

  task automatic push_frame(input int code);
    exp_t e;
    int kb, h, a;
    logic [3:0] en_b, se_b;
    kb = (code == 0) ? 2 : 3;
    for (int t = 0; t < kb; t++) begin
      for (int w = 0; w < 4; w++) begin
        e = '0;
        e.col  = 4'(t);
        e.word = 3'(w);
        e.sof  = (t == 0) && (w == 0);
        e.eof  = (t == kb - 1) && (w == 3);
        for (int r = 0; r < 2; r++) begin
          h = hb(code, r, t);
          en_b = 4'b0000;
          se_b = 4'b0000;
          if (h < 0) begin
            se_b[0] = 1'b1;
            e.sh[r] = 3'd0;
          end else begin
            a = (4 - ((h / 4) % 4)) % 4;
            se_b[a] = 1'b1;
            en_b[a] = 1'b1;
            en_b[(a + 3) % 4] = 1'b1;
            e.sh[r] = 3'(h % 4);
          end
          for (int i = 0; i < w; i++) begin
            en_b = {en_b[2:0], en_b[3]};
            se_b = {se_b[2:0], se_b[3]};
          end
          e.ena[r] = en_b;
          e.sel[r] = se_b;
        end
        sb.push_back(e);
      end
    end
  endtask

  // Compare current outputs, drive inputs, then advance the model across the clock edge.
  task automatic tick(input logic st, input logic [1:0] cd, input logic en);
    exp_t e;
    @(negedge iclk);
    check_val("oval", oval, sb.size() > 0);
    check_val("obusy", obusy, sb.size() > 0);
    check_val("odone", odone, exp_done);
    check_val("oerr", oerr, exp_err);
    if (sb.size() > 0) begin
      e = sb[0];
      check_val("ocol", ocol, e.col);
      check_val("oword", oword, e.word);
      check_val("osof", osof, e.sof);
      check_val("oeof", oeof, e.eof);
      for (int r = 0; r < 2; r++) begin
        check_val("bitena", obitena[r], e.ena[r]);
        check_val("bitsel", obitsel[r], e.sel[r]);
        check_val("bitshift", obitshift[r], e.sh[r]);
      end
    end else begin
      check_val("osof_idle", osof, 0);
      check_val("oeof_idle", oeof, 0);
      for (int r = 0; r < 2; r++) begin
        check_val("bitena_hold", obitena[r], last.ena[r]);
        check_val("bitsel_hold", obitsel[r], last.sel[r]);
        check_val("bitshift_hold", obitshift[r], last.sh[r]);
      end
    end
    istart  = st;
    icode   = cd;
    ienable = en;
    @(posedge iclk);
    if (iclkena) begin
      exp_done = 1'b0;
      exp_err  = 1'b0;
      if (st) begin
        if (sb.size() > 0) last = sb[0];
        sb.delete();
        acc_cnt = 0;
        if (cd < 2) push_frame(int'(cd));
        else exp_err = 1'b1;
      end else if (sb.size() > 0 && en) begin
        e = sb.pop_front();
        last = e;
        acc_cnt++;
        if (e.eof) exp_done = 1'b1;
      end
    end
    #1;
  endtask

  task automatic run_frame(input int max_cyc, input bit rnd);
    for (int i = 0; i < max_cyc && sb.size() > 0; i++)
      tick(1'b0, 2'd0, rnd ? 1'($urandom_range(0, 1)) : 1'b1);
    check_val("frame_timeout", sb.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    ireset = 1'b1; iclkena = 1'b1; istart = 1'b0; icode = 2'd0; ienable = 1'b0;
    exp_done = 1'b0; exp_err = 1'b0; last = '0; acc_cnt = 0;
    repeat (2) @(posedge iclk);
    #1;
    check_val("rst_oval", oval, 0);
    check_val("rst_obusy", obusy, 0);
    check_val("rst_masks", {obitena[0], obitena[1], obitsel[0], obitsel[1]}, 0);
    @(negedge iclk);
    ireset = 1'b0;

    // Code 0 with ienable held high, literal first-column and second-column values.
    tick(1'b1, 2'd0, 1'b1);
    check_val("start_sof", osof, 1);
    check_val("c0_sel0", obitsel[0], 4'b1000);
    check_val("c0_ena0", obitena[0], 4'b1100);
    check_val("c0_sh0", obitshift[0], 1);
    check_val("h0_sel", obitsel[1], 4'b0001);
    check_val("h0_ena", obitena[1], 4'b1001);
    check_val("h0_sh", obitshift[1], 0);
    repeat (4) tick(1'b0, 2'd0, 1'b1);
    check_val("c1_ena0", obitena[0], 4'b0000);
    check_val("c1_sel0", obitsel[0], 4'b0001);
    check_val("c1_sh0", obitshift[0], 0);
    check_val("h14_sel", obitsel[1], 4'b0010);
    check_val("h14_ena", obitena[1], 4'b0011);
    check_val("h14_sh", obitshift[1], 2);
    run_frame(10, 1'b0);
    check_val("c0_words", acc_cnt, 8);

    // Back-to-back start of code 1 while odone is high, then random stalls.
    tick(1'b1, 2'd1, 1'b1);
    check_val("b2b_sof", osof, 1);
    run_frame(400, 1'b1);
    check_val("c1_words", acc_cnt, 12);

    // Restart mid-frame with code 1, then reject invalid codes.
    tick(1'b1, 2'd0, 1'b1);
    repeat (5) tick(1'b0, 2'd0, 1'b1);
    tick(1'b1, 2'd1, 1'b1);
    check_val("restart_sof", osof, 1);
    check_val("restart_nodone", odone, 0);
    run_frame(20, 1'b0);
    check_val("restart_words", acc_cnt, 12);
    tick(1'b1, 2'd3, 1'b0);
    check_val("bad_err", oerr, 1);
    check_val("bad_busy", obusy, 0);
    tick(1'b1, 2'd0, 1'b1);
    repeat (2) tick(1'b0, 2'd0, 1'b1);
    tick(1'b1, 2'd2, 1'b1);
    check_val("abort_err", oerr, 1);
    tick(1'b0, 2'd0, 1'b0);

    // Asynchronous reset between clock edges in the middle of a frame.
    tick(1'b1, 2'd1, 1'b1);
    repeat (3) tick(1'b0, 2'd0, 1'b1);
    #2 ireset = 1'b1;
    #1;
    check_val("arst_oval", oval, 0);
    check_val("arst_obusy", obusy, 0);
    check_val("arst_pos", {ocol, oword}, 0);
    check_val("arst_masks", {obitena[0], obitena[1], obitsel[0], obitsel[1]}, 0);
    check_val("arst_shift", {obitshift[0], obitshift[1]}, 0);
    check_val("arst_flags", {osof, oeof, odone, oerr}, 0);
    sb.delete(); exp_done = 1'b0; exp_err = 1'b0; last = '0; acc_cnt = 0;
    @(negedge iclk);
    ireset = 1'b0;
    tick(1'b1, 2'd1, 1'b1);
    run_frame(20, 1'b0);
    check_val("post_rst_words", acc_cnt, 12);

    // Clock-enable freeze around the end of a frame.
    tick(1'b1, 2'd0, 1'b1);
    repeat (7) tick(1'b0, 2'd0, 1'b1);
    check_val("pre_freeze_eof", oeof, 1);
    iclkena = 1'b0;
    repeat (3) tick(1'b0, 2'd0, 1'b1);
    check_val("freeze_nodone", odone, 0);
    check_val("freeze_eof", oeof, 1);
    iclkena = 1'b1;
    tick(1'b0, 2'd0, 1'b1);
    check_val("done_pulse", odone, 1);
    iclkena = 1'b0;
    repeat (3) tick(1'b0, 2'd0, 1'b0);
    check_val("done_frozen", odone, 1);
    iclkena = 1'b1;
    tick(1'b0, 2'd0, 1'b0);
    check_val("done_clear", odone, 0);
    tick(1'b0, 2'd0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
